// File: rtl/avr_cpu_muldiv_seq_if.sv
// Handshake and operand bundle between the AVR sequencer and the iterative multiplier.
interface avr_cpu_muldiv_seq_if #(parameter int WIDTH = 8);
  logic                 start;
  logic                 abort;
  logic [2:0]           opcode;
  logic [WIDTH-1:0]     d_in;
  logic [WIDTH-1:0]     r_in;
  logic [7:0]           status_in;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   result;
  logic [7:0]           status_out;

  modport master (
    output start, abort, opcode, d_in, r_in, status_in,
    input  busy, done, result, status_out
  );

  modport slave (
    input  start, abort, opcode, d_in, r_in, status_in,
    output busy, done, result, status_out
  );
endinterface

// File: rtl/avr_cpu_muldiv_seq.sv
// Iterative MUL/MULS/MULSU/FMUL/FMULS/FMULSU; done WIDTH/BITS_PER_CYCLE+2 cycles after accept.
// No stalls inside: start is ignored while busy, abort cancels without producing done.
module avr_cpu_muldiv_seq #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  avr_cpu_muldiv_seq_if.slave bus
);
  localparam int W   = WIDTH;
  localparam int B   = BITS_PER_CYCLE;
  localparam int N   = W / B;
  localparam int CW  = $clog2(N + 1);
  localparam int PW  = W + B;
  localparam int PRW = 2 * W;
  localparam int AW  = 2 * W + B;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, FIX} state_t;

  state_t           state, state_nxt;
  logic [2:0]       op_q;
  logic [7:0]       st_q, sta_q, sta_fix;
  logic [W-1:0]     d_q, r_q, mag_d, mag_r;
  logic             sd, sr, neg_q;
  logic [AW-1:0]    acc, acc_step;
  logic [PW-1:0]    partial, sum;
  logic [PRW-1:0]   prod, res_fix, res_q;
  logic [CW-1:0]    cnt;
  logic             accept, busy_c, done_c;

  // Datapath: magnitudes, one shift-add step, and the sign/fraction fix-up.
  always_comb begin
    sd       = ((op_q[1:0] == 2'b01) || (op_q[1:0] == 2'b10)) && d_q[W-1];
    sr       = (op_q[1:0] == 2'b01) && r_q[W-1];
    mag_d    = sd ? (~d_q + W'(1)) : d_q;
    mag_r    = sr ? (~r_q + W'(1)) : r_q;
    partial  = PW'(d_q) * PW'(acc[B-1:0]);
    sum      = acc[AW-1:W] + partial;
    acc_step = {sum, acc[W-1:0]} >> B;
    prod     = neg_q ? (~acc[PRW-1:0] + PRW'(1)) : acc[PRW-1:0];
    res_fix  = op_q[2] ? {prod[PRW-2:0], 1'b0} : prod;
    // Only C and Z are rewritten; the rest of SREG passes through untouched.
    sta_fix  = (st_q & 8'hFC) | {6'b0, (res_fix == '0), prod[PRW-1]};
  end

  always_comb begin
    state_nxt = state;
    busy_c    = (state != IDLE);
    done_c    = 1'b0;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          state_nxt = LOAD;
          accept    = 1'b1;
        end
      end
      LOAD: state_nxt = bus.abort ? IDLE : RUN;
      RUN: begin
        if (bus.abort)
          state_nxt = IDLE;
        else if (cnt == CW'(1))
          state_nxt = FIX;
      end
      FIX: begin
        state_nxt = IDLE;
        done_c    = !bus.abort;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= '0;
      st_q  <= '0;
      d_q   <= '0;
      r_q   <= '0;
      neg_q <= 1'b0;
      acc   <= '0;
      cnt   <= '0;
      res_q <= '0;
      sta_q <= '0;
    end else begin
      if (accept) begin
        op_q <= bus.opcode;
        st_q <= bus.status_in;
        d_q  <= bus.d_in;
        r_q  <= bus.r_in;
      end
      // d_q is reused to hold |d| for the rest of the operation.
      if (state == LOAD) begin
        d_q   <= mag_d;
        acc   <= AW'(mag_r);
        neg_q <= sd ^ sr;
        cnt   <= CW'(N);
      end
      if (state == RUN) begin
        acc <= acc_step;
        cnt <= cnt - CW'(1);
      end
      if (done_c) begin
        res_q <= res_fix;
        sta_q <= sta_fix;
      end
    end
  end

  assign bus.busy       = busy_c;
  assign bus.done       = done_c;
  assign bus.result     = done_c ? res_fix : res_q;
  assign bus.status_out = done_c ? sta_fix : sta_q;
endmodule
